board_store: RTL

Registered 64-square chess board memory between `game_logic` (single-square writes) and `display_interface` plus `game_logic` (packed 256-bit board reads). On reset or on request, a 64-cycle sweep loads the standard starting position. It also provides a registered single-square read port and rejects writes that arrive during the sweep. It replaces the ad-hoc board register array and initial-position block at the chess top level.

---
 rtl/board_store_pkg.sv | 49 ++++
 rtl/board_store_start_position_rom.sv | 28 ++
 rtl/board_store.sv | 93 +++++++++
 3 files changed

// File: rtl/board_store_pkg.sv
// Shared chess definitions: piece and color encodings, square address
// fields and the board-store state type, used by the board store, the
// game logic and the display interface.
package chess_defs;

   localparam int SQUARES = 64;
   localparam int PIECE_W = 4;
   localparam int ROW_W   = 3;
   localparam int COL_W   = 3;
   localparam int ADDR_W  = ROW_W + COL_W;
   localparam int BOARD_W = SQUARES * PIECE_W;

   typedef enum logic [2:0] {
      PIECE_NONE   = 3'd0,
      PIECE_PAWN   = 3'd1,
      PIECE_KNIGHT = 3'd2,
      PIECE_BISHOP = 3'd3,
      PIECE_ROOK   = 3'd4,
      PIECE_QUEEN  = 3'd5,
      PIECE_KING   = 3'd6
   } piece_e;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } board_state_e;

   // Square encoding is {color, piece}.
   function automatic logic [PIECE_W-1:0] make_piece(input logic color, input piece_e piece);
      return {color, piece};
   endfunction

   // Back-rank order from column 0 to 7: R N B Q K B N R.
   function automatic piece_e back_rank_piece(input logic [COL_W-1:0] col);
      piece_e p;
      case (col)
         3'd0, 3'd7: p = PIECE_ROOK;
         3'd1, 3'd6: p = PIECE_KNIGHT;
         3'd2, 3'd5: p = PIECE_BISHOP;
         3'd3:       p = PIECE_QUEEN;
         default:    p = PIECE_KING;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/board_store_start_position_rom.sv
// Combinational table of the standard starting position, indexed by
// square address {row, col}. Black occupies rows 0-1, white rows 6-7.
module start_position_rom
   import chess_defs::*;
(
   input  logic [ADDR_W-1:0]  addr,
   output logic [PIECE_W-1:0] piece
);

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;

   assign row = addr[ADDR_W-1:COL_W];
   assign col = addr[COL_W-1:0];

   // Decode the starting piece for the addressed square.
   always_comb begin
      piece = make_piece(COLOR_WHITE, PIECE_NONE);
      case (row)
         3'd0:    piece = make_piece(COLOR_BLACK, back_rank_piece(col));
         3'd1:    piece = make_piece(COLOR_BLACK, PIECE_PAWN);
         3'd6:    piece = make_piece(COLOR_WHITE, PIECE_PAWN);
         3'd7:    piece = make_piece(COLOR_WHITE, back_rank_piece(col));
         default: piece = make_piece(COLOR_WHITE, PIECE_NONE);
      endcase
   end

endmodule

// File: rtl/board_store.sv
// Registered 64-square board memory. A sweep loads the starting position
// after reset or on INIT_REQ; game-logic writes are accepted only once the
// sweep has finished and are rejected (with a pulse) while it runs.
module board_store
   import chess_defs::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                INIT_REQ,
   input  logic                WR_EN,
   input  logic [ADDR_W-1:0]   WR_ADDR,
   input  logic [PIECE_W-1:0]  WR_PIECE,
   input  logic [ADDR_W-1:0]   RD_ADDR,
   output logic [PIECE_W-1:0]  RD_PIECE,
   output logic [BOARD_W-1:0]  BOARD,
   output logic                BUSY,
   output logic                WR_REJECT
);

   // Flop storage: the whole board is exposed every cycle, so it cannot
   // live in a block RAM.
   logic [SQUARES-1:0][PIECE_W-1:0] board_q, board_d;
   board_state_e                    state_q, state_d;
   logic [ADDR_W-1:0]               cnt_q, cnt_d;
   logic [PIECE_W-1:0]              rd_piece_q, rd_piece_d;
   logic                            wr_reject_q, wr_reject_d;
   logic [PIECE_W-1:0]              rom_piece;

   start_position_rom u_rom (
      .addr  (cnt_q),
      .piece (rom_piece)
   );

   // Next-state: sweep stepping, write acceptance/rejection and read port.
   always_comb begin
      board_d     = board_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_reject_d = 1'b0;
      // Read uses the pre-edge contents, so a same-cycle write returns old data.
      rd_piece_d  = board_q[RD_ADDR];

      case (state_q)
         S_INIT: begin
            // Any game-logic write during the sweep is dropped.
            wr_reject_d = WR_EN;
            if (INIT_REQ) begin
               // Restart: the next edge writes square 0.
               cnt_d = '0;
            end else begin
               board_d[cnt_q] = rom_piece;
               cnt_d          = cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(SQUARES - 1)) begin
                  state_d = S_RUN;
               end
            end
         end
         default: begin
            if (INIT_REQ) begin
               // A sweep request has priority over a simultaneous write.
               state_d     = S_INIT;
               cnt_d       = '0;
               wr_reject_d = WR_EN;
            end else if (WR_EN) begin
               board_d[WR_ADDR] = WR_PIECE;
            end
         end
      endcase
   end

   // State registers with synchronous clear; reset starts a fresh sweep.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         board_q     <= '0;
         state_q     <= S_INIT;
         cnt_q       <= '0;
         rd_piece_q  <= '0;
         wr_reject_q <= 1'b0;
      end else begin
         board_q     <= board_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_piece_q  <= rd_piece_d;
         wr_reject_q <= wr_reject_d;
      end
   end

   assign BOARD     = board_q;
   assign RD_PIECE  = rd_piece_q;
   assign BUSY      = (state_q == S_INIT);
   assign WR_REJECT = wr_reject_q;

endmodule
